e_mdu: RTL and testbench

- Multi-cycle multiply/divide unit in the Execute stage; receives the same forwarded operands A/B as the E-stage ALU.
- Its result joins the ALU result at the E-stage result mux.
- Owns the HI/LO architectural registers.
- Executes mult/multu/div/divu over a fixed latency, and mfhi/mflo/mthi/mtlo in a single cycle.
- Exports `busy` so the hazard unit stalls MDU instructions in D.

---
 rtl/e_mdu.sv | 150 +++++++++++++++
 tb/tb_e_mdu.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// e_mdu: Execute-stage multiply/divide unit that owns the HI/LO architectural registers.
// Build option: define MDU_MADD_EN to add the madd/maddu/msub accumulate datapath.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDUEn,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUout
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
`endif

    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the
    // dividend. 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    function automatic logic [63:0] div_s(input logic signed [31:0] n, input logic signed [31:0] d);
        logic [31:0] un, ud, uq, ur, q, r;
        un = n[31] ? 32'(-n) : 32'(n);
        ud = d[31] ? 32'(-d) : 32'(d);
        if (ud == 32'd0) ud = 32'd1;
        uq = un / ud;
        ur = un % ud;
        q  = (n[31] ^ d[31]) ? (32'd0 - uq) : uq;
        r  = n[31] ? (32'd0 - ur) : ur;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_u(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] dd;
        dd = (d == 32'd0) ? 32'd1 : d;
        return {n % dd, n / dd};
    endfunction

    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               accept;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign accept = MDUEn && !busy_q;

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        cnt_d    = cnt_q;
        if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                hi_d = hi_tmp_q;
                lo_d = lo_tmp_q;
            end
        end else if (accept) begin
            case (MDUOp)
                OP_MULT: begin
                    {hi_tmp_d, lo_tmp_d} = $unsigned(prod_s);
                    cnt_d = MULT_LOAD;
                end
                OP_MULTU: begin
                    {hi_tmp_d, lo_tmp_d} = prod_u;
                    cnt_d = MULT_LOAD;
                end
                // A zero divisor recommits the current HI/LO, so commit leaves them unchanged.
                OP_DIV: begin
                    {hi_tmp_d, lo_tmp_d} = (B == 32'd0) ? {hi_q, lo_q} : div_s($signed(A), $signed(B));
                    cnt_d = DIV_LOAD;
                end
                OP_DIVU: begin
                    {hi_tmp_d, lo_tmp_d} = (B == 32'd0) ? {hi_q, lo_q} : div_u(A, B);
                    cnt_d = DIV_LOAD;
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
                OP_MADD: begin
                    {hi_tmp_d, lo_tmp_d} = {hi_q, lo_q} + $unsigned(prod_s);
                    cnt_d = MULT_LOAD;
                end
                OP_MADDU: begin
                    {hi_tmp_d, lo_tmp_d} = {hi_q, lo_q} + prod_u;
                    cnt_d = MULT_LOAD;
                end
                OP_MSUB: begin
                    {hi_tmp_d, lo_tmp_d} = {hi_q, lo_q} - $unsigned(prod_s);
                    cnt_d = MULT_LOAD;
                end
`endif
                default: ;
            endcase
        end
        busy_d = (cnt_d != CNT_ZERO);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_tmp_q <= 32'd0;
            lo_tmp_q <= 32'd0;
            cnt_q    <= CNT_ZERO;
            busy_q   <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign MDUout = (MDUOp == OP_MFHI) ? hi_q :
                    (MDUOp == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus pushes expected results, a negedge monitor checks them.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        MDUEn;
    logic [3:0]  MDUOp;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO, MDUout;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .MDUEn(MDUEn), .MDUOp(MDUOp), .A(A), .B(B),
        .busy(busy), .HI(HI), .LO(LO), .MDUout(MDUout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_commit;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] mout;
        int          len;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          run   = 0;
    bit          snap_req = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: a busy falling edge is a commit (or reset abort); snap_req marks an idle probe.
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            run++;
        end else if (run != 0) begin
            if (sbq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL commit_unexpected: got busy run %0d expected none", run);
            end else begin
                e = sbq.pop_front();
                chk("commit_kind", {31'd0, e.is_commit}, 32'd1);
                chk("busy_len", run, e.len);
                chk("commit_hi", HI, e.hi);
                chk("commit_lo", LO, e.lo);
            end
            run = 0;
        end
        if (snap_req) begin
            if (sbq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL snap_missing: got empty queue expected probe entry");
            end else begin
                e = sbq.pop_front();
                chk("snap_kind", {31'd0, e.is_commit}, 32'd0);
                chk("snap_busy", {31'd0, busy}, 32'd0);
                chk("snap_hi", HI, e.hi);
                chk("snap_lo", LO, e.lo);
                chk("snap_mduout", MDUout, e.mout);
            end
        end
    end

    // Reference model: architectural effect of one accepted op; n = expected busy cycles.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        longint          sa, sb, q, r, p;
        longint unsigned ua, ub, acc, up;
        sa = $signed(a); sb = $signed(b);
        ua = a;          ub = b;
        acc = {m_hi, m_lo};
        n = 0;
        case (op)
            4'd1: begin p = sa * sb; {m_hi, m_lo} = p; n = MC; end
            4'd2: begin up = ua * ub; {m_hi, m_lo} = up; n = MC; end
            4'd3: begin
                n = DC;
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end
            end
            4'd4: begin
                n = DC;
                if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            end
            4'd7: m_hi = a;
            4'd8: m_lo = a;
`ifdef MDU_MADD_EN
            4'd9:  begin p = sa * sb; acc = acc + longint'(p); {m_hi, m_lo} = acc; n = MC; end
            4'd10: begin up = ua * ub; acc = acc + up; {m_hi, m_lo} = acc; n = MC; end
            4'd11: begin p = sa * sb; acc = acc - longint'(p); {m_hi, m_lo} = acc; n = MC; end
`endif
            default: ;
        endcase
    endtask

    task automatic idle();
        MDUEn = 1'b0; MDUOp = 4'd0; A = $urandom; B = $urandom;
    endtask

    task automatic snap(input logic [31:0] mout);
        exp_t e;
        e.is_commit = 1'b0; e.hi = m_hi; e.lo = m_lo; e.mout = mout; e.len = 0;
        sbq.push_back(e);
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
    endtask

    task automatic push_commit(input int n);
        exp_t e;
        e.is_commit = 1'b1; e.hi = m_hi; e.lo = m_lo; e.mout = 32'd0; e.len = n;
        sbq.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        model(op, a, b, n);
        if (n != 0) push_commit(n);
        MDUEn = 1'b1; MDUOp = op; A = a; B = b;
        @(posedge clk); #1;
        idle();
        if (n != 0) repeat (n) begin @(posedge clk); #1; end
        snap(32'd0);
    endtask

    task automatic rd(input logic [3:0] op);
        MDUEn = 1'b1; MDUOp = op; A = $urandom; B = $urandom;
        snap(op == 4'd5 ? m_hi : m_lo);
        idle();
    endtask

    initial begin
        int n;
        logic [3:0]  op;
        logic [31:0] a, b;

        // Reset held two cycles with an mthi presented that must be ignored.
        reset = 1'b0; MDUEn = 1'b1; MDUOp = 4'd7; A = 32'h12345678; B = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idle();
        snap(32'd0);

        issue(4'd1, 32'hFFFFFFFF, 32'd2);
        issue(4'd2, 32'hFFFFFFFF, 32'd2);
        issue(4'd3, 32'hFFFFFFF9, 32'd2);
        issue(4'd4, 32'd7, 32'd2);
        issue(4'd7, 32'hAAAA0000, 32'd0);
        issue(4'd8, 32'h00005555, 32'd0);
        issue(4'd3, 32'd5, 32'd0);
        issue(4'd4, 32'd5, 32'd0);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);

        // Ops presented while busy must be dropped.
        model(4'd1, 32'd3, 32'd4, n);
        push_commit(n);
        MDUEn = 1'b1; MDUOp = 4'd1; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        MDUOp = 4'd8; A = 32'd9;
        @(posedge clk); #1;
        MDUOp = 4'd4; A = 32'd7; B = 32'd2;
        @(posedge clk); #1;
        idle();
        repeat (MC - 2) begin @(posedge clk); #1; end
        snap(32'd0);

        issue(4'd7, 32'd1, 32'd0);
        rd(4'd5);
        rd(4'd6);

        issue(4'd7, 32'd0, 32'd0);
        issue(4'd8, 32'hFFFFFFFF, 32'd0);
        issue(4'd10, 32'd1, 32'd1);

        // Reset two cycles into a mult: aborted run, no later commit.
        m_hi = 32'd0; m_lo = 32'd0;
        push_commit(2);
        MDUEn = 1'b1; MDUOp = 4'd1; A = 32'h1234; B = 32'h5678;
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        snap(32'd0);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if ($urandom_range(0, 5) == 0) b = 32'($urandom_range(1, 5));
            if (op == 4'd5 || op == 4'd6) rd(op);
            else issue(op, a, b);
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
